// File: rtl/coax_pkg.sv
// Shared tags, FSM state encoding and byte-format helpers for the coax RX byte streamer.
package coax_pkg;

  localparam int COUNT_WIDTH_DEF = 16;

  localparam logic [1:0] TAG_WORD = 2'b01;
  localparam logic [1:0] TAG_EOF  = 2'b10;
  localparam logic [1:0] TAG_ERR  = 2'b11;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WORD_HI    = 3'd1;
  localparam logic [2:0] ST_WORD_LO    = 3'd2;
  localparam logic [2:0] ST_EOF_MARK   = 3'd3;
  localparam logic [2:0] ST_EOF_CNT_HI = 3'd4;
  localparam logic [2:0] ST_EOF_CNT_LO = 3'd5;
  localparam logic [2:0] ST_ERR_MARK   = 3'd6;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    WORD_HI    = ST_WORD_HI,
    WORD_LO    = ST_WORD_LO,
    EOF_MARK   = ST_EOF_MARK,
    EOF_CNT_HI = ST_EOF_CNT_HI,
    EOF_CNT_LO = ST_EOF_CNT_LO,
    ERR_MARK   = ST_ERR_MARK
  } state_e;

  function automatic logic [7:0] word_hi_byte(input logic perr, input logic [1:0] d_hi);
    return {TAG_WORD, 3'b000, perr, d_hi};
  endfunction

  function automatic logic [7:0] marker_byte(input logic [1:0] tag);
    return {tag, 6'b000000};
  endfunction

endpackage

// File: rtl/coax_rx_frame_tracker.sv
// Registers rx_active/rx_error, detects frame-end and error-start edges, and holds the
// resulting eof/err pending flags until the streamer clears them.
module coax_rx_frame_tracker (
  input  logic clk,
  input  logic reset,
  input  logic rx_active_i,
  input  logic rx_error_i,
  input  logic cnt_nz_i,
  input  logic eof_clr_i,
  input  logic err_clr_i,
  output logic eof_pending_o,
  output logic err_pending_o
);

  logic active_q;
  logic error_q;
  logic eof_pending_q;
  logic err_pending_q;

  logic active_fall;
  logic error_rise;

  assign active_fall = active_q && !rx_active_i;
  assign error_rise  = rx_error_i && !error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= 1'b0;
      error_q       <= 1'b0;
      eof_pending_q <= 1'b0;
      err_pending_q <= 1'b0;
    end else begin
      active_q <= rx_active_i;
      error_q  <= rx_error_i;
      // An empty frame produces no EOF; a clear retires the flag even if another frame just ended.
      if (eof_clr_i) begin
        eof_pending_q <= 1'b0;
      end else if (active_fall && cnt_nz_i) begin
        eof_pending_q <= 1'b1;
      end
      if (error_rise) begin
        err_pending_q <= 1'b1;
      end else if (err_clr_i) begin
        err_pending_q <= 1'b0;
      end
    end
  end

  assign eof_pending_o = eof_pending_q;
  assign err_pending_o = err_pending_q;

endmodule

// File: rtl/coax_rx_byte_streamer.sv
// Turns RX FIFO words, frame ends and receiver errors into a tagged, self-describing byte stream.
// Optional parity checking of each popped word: COAX_RX_STREAMER_PARITY_CHECK_EN.
module coax_rx_byte_streamer
  import coax_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] fifo_data,
  input  logic       fifo_parity,
  input  logic       fifo_empty,
  output logic       fifo_read_strobe,
  input  logic       rx_active,
  input  logic       rx_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int SNAP_W = (COUNT_WIDTH < 16) ? COUNT_WIDTH : 16;

  state_e                 state_q;
  logic [7:0]             out_data_q;
  logic                   out_valid_q;
  logic                   strobe_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [7:0]             lo_q;
  logic [15:0]            snap_q;

  logic eof_pending;
  logic err_pending;
  logic accept;
  logic eof_clr;
  logic err_clr;
  logic perr_d;

`ifdef COAX_RX_STREAMER_PARITY_CHECK_EN
  assign perr_d = fifo_parity ^ (^fifo_data);
`else
  logic unused_parity;
  assign unused_parity = fifo_parity;
  assign perr_d        = 1'b0;
`endif

  assign accept  = out_valid_q && out_ready;
  assign err_clr = accept && (state_q == ERR_MARK);
  assign eof_clr = err_clr || (accept && (state_q == EOF_CNT_LO));

  coax_rx_frame_tracker u_tracker (
    .clk           (clk),
    .reset         (reset),
    .rx_active_i   (rx_active),
    .rx_error_i    (rx_error),
    .cnt_nz_i      (cnt_q != '0),
    .eof_clr_i     (eof_clr),
    .err_clr_i     (err_clr),
    .eof_pending_o (eof_pending),
    .err_pending_o (err_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      cnt_q       <= '0;
      lo_q        <= 8'h00;
      snap_q      <= 16'h0000;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (err_pending) begin
            state_q     <= ERR_MARK;
            out_data_q  <= marker_byte(TAG_ERR);
            out_valid_q <= 1'b1;
          end else if (!fifo_empty) begin
            state_q     <= WORD_HI;
            out_data_q  <= word_hi_byte(perr_d, fifo_data[9:8]);
            lo_q        <= fifo_data[7:0];
            out_valid_q <= 1'b1;
            strobe_q    <= 1'b1;
            // Words of a frame that began before its predecessor's EOF went out stay uncounted.
            if (!eof_pending && !(&cnt_q)) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (eof_pending) begin
            state_q     <= EOF_MARK;
            snap_q      <= 16'(cnt_q[SNAP_W-1:0]);
            out_data_q  <= marker_byte(TAG_EOF);
            out_valid_q <= 1'b1;
          end
        end
        WORD_HI: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            state_q     <= WORD_LO;
          end
        end
        WORD_LO: begin
          if (!out_valid_q) begin
            out_data_q  <= lo_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        EOF_MARK: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            state_q     <= EOF_CNT_HI;
          end
        end
        EOF_CNT_HI: begin
          if (!out_valid_q) begin
            out_data_q  <= snap_q[15:8];
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= EOF_CNT_LO;
          end
        end
        EOF_CNT_LO: begin
          if (!out_valid_q) begin
            out_data_q  <= snap_q[7:0];
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        ERR_MARK: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign fifo_read_strobe = strobe_q;

endmodule
